// File: rtl/axi4_master_rd_burst.sv
// Single-outstanding AXI4 read-burst master: one SRAM-style request becomes one
// AR burst, and the R beats stream back with valid/ready backpressure.
module axi4_master_rd_burst #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int BURST_LEN = 4,
  parameter int WRAP_MODE = 0,
  parameter int ID_W      = 4,
  parameter int ID_VAL    = 0
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  // request / response side
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              rsp_err,
  output logic              proto_err,
  // AXI4 AR channel
  output logic              ARVALID,
  input  logic              ARREADY,
  output logic [ADDR_W-1:0] ARADDR,
  output logic [ID_W-1:0]   ARID,
  output logic [7:0]        ARLEN,
  output logic [2:0]        ARSIZE,
  output logic [1:0]        ARBURST,
  output logic              ARLOCK,
  output logic [3:0]        ARCACHE,
  output logic [2:0]        ARPROT,
  output logic [3:0]        ARQOS,
  output logic [3:0]        ARREGION,
  // AXI4 R channel
  input  logic              RVALID,
  output logic              RREADY,
  input  logic [DATA_W-1:0] RDATA,
  input  logic [ID_W-1:0]   RID,
  input  logic [1:0]        RRESP,
  input  logic              RLAST
);

  localparam int BYTES      = DATA_W / 8;
  localparam int SIZE       = $clog2(BYTES);
  localparam int LINE_BITS  = $clog2(BURST_LEN * BYTES);
  localparam int CNT_W      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  // INCR fetches the whole aligned line; WRAP starts at the requested word.
  localparam int ALIGN_BITS = (WRAP_MODE != 0) ? SIZE : LINE_BITS;

  localparam logic [ADDR_W-1:0] ALIGN_MASK = {ADDR_W{1'b1}} << ALIGN_BITS;
  localparam logic [CNT_W-1:0]  LAST_CNT   = CNT_W'(BURST_LEN - 1);
  localparam logic [ID_W-1:0]   ID_C       = ID_W'(ID_VAL);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA
  } state_t;

  state_t             state_q, state_d;
  logic               arvalid_q;
  logic [ADDR_W-1:0]  araddr_q;
  logic [CNT_W-1:0]   beat_cnt_q;
  logic               proto_err_q;
  logic               in_data;
  logic               beat_acc;
  logic               rresp_unused;

  assign in_data  = (state_q == S_DATA);
  assign beat_acc = RVALID && RREADY;

  // Constant AR attributes.
  assign ARID     = ID_C;
  assign ARLEN    = 8'(BURST_LEN - 1);
  assign ARSIZE   = 3'(SIZE);
  assign ARBURST  = (WRAP_MODE != 0) ? 2'b10 : 2'b01;
  assign ARLOCK   = 1'b0;
  assign ARCACHE  = 4'd0;
  assign ARPROT   = 3'd0;
  assign ARQOS    = 4'd0;
  assign ARREGION = 4'd0;

  assign ARVALID   = arvalid_q;
  assign ARADDR    = araddr_q;
  assign proto_err = proto_err_q;

  // req_ready is gated by reset so every state-derived output reads 0 while held in reset.
  assign req_ready = ARESETn && (state_q == S_IDLE);
  assign RREADY    = in_data && rsp_ready;
  assign rsp_valid = in_data && RVALID;
  assign rsp_data  = in_data ? RDATA : '0;
  assign rsp_last  = in_data && (beat_cnt_q == LAST_CNT);
  assign rsp_err   = in_data && RRESP[1];

  assign rresp_unused = RRESP[0];

  // NOTE: every always_comb target gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (req_valid)                 state_d = S_ADDR;
      S_ADDR: if (ARREADY)                   state_d = S_DATA;
      S_DATA: if (beat_acc && rsp_last)      state_d = S_IDLE;
      default:                               state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q     <= S_IDLE;
      arvalid_q   <= 1'b0;
      araddr_q    <= '0;
      beat_cnt_q  <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      arvalid_q <= (state_d == S_ADDR);

      if (state_q == S_IDLE && req_valid)
        araddr_q <= req_addr & ALIGN_MASK;

      if (state_q == S_ADDR && ARREADY)
        beat_cnt_q <= '0;
      else if (in_data && beat_acc)
        beat_cnt_q <= beat_cnt_q + 1'b1;

      // Beat count alone ends the burst; RID/RLAST disagreements only raise the flag.
      if ((beat_acc && ((RID != ID_C) || (RLAST != rsp_last))) || (RVALID && !in_data))
        proto_err_q <= 1'b1;
    end
  end

endmodule

// File: doc/axi4_master_rd_burst.md
Name: axi4_master_rd_burst

Overview:
Parametrised successor to the single-beat instruction-fetch AXI4 read master. It converts one SRAM-style read request into one AXI4 read burst of configurable length, width and burst type, and streams each beat back with valid/ready backpressure. It adds RID/RLAST checking, per-beat error reporting and a sticky protocol-error flag. It sits between a cache refill or fetch unit and the AXI4 interconnect, and is read-only.

Parameters:
ADDR_W, 32, request/AR address width
DATA_W, 32, R data width; one of 32/64/128
BURST_LEN, 4, beats per burst; 1..16
WRAP_MODE, 0, 0 = INCR burst at line-aligned address; 1 = WRAP burst at requested word (critical-word-first); requires BURST_LEN in {2,4,8,16}
ID_W, 4, AXI ID width
ID_VAL, 0, constant ARID value

Ports:
ACLK  in  1  clock
ARESETn  in  1  asynchronous active-low reset
req_valid  in  1  read request
req_ready  out  1  request accepted
req_addr  in  ADDR_W  byte address
rsp_valid  out  1  beat valid
rsp_ready  in  1  consumer accepts beat
rsp_data  out  DATA_W  beat data
rsp_last  out  1  final beat of burst
rsp_err  out  1  RRESP[1] set on this beat
proto_err  out  1  sticky: RID mismatch or RLAST mismatch
ARVALID  out  1  AR valid
ARREADY  in  1  AR ready
ARADDR  out  ADDR_W  burst start address
ARID  out  ID_W  fixed ID_VAL
ARLEN  out  8  BURST_LEN-1
ARSIZE  out  3  log2(DATA_W/8)
ARBURST  out  2  01 INCR / 10 WRAP
ARLOCK, ARCACHE, ARPROT, ARQOS, ARREGION  out  1/4/3/4/4  tied to 0
RVALID  in  1  R valid
RREADY  out  1  R ready
RDATA  in  DATA_W  R data
RID  in  ID_W  R ID
RRESP  in  2  response
RLAST  in  1  last beat

Behaviour:
- Reset asynchronous on ARESETn low. State returns to IDLE. ARVALID=0, ARADDR=0, beat counter=0, proto_err=0. All outputs derived from state read 0 during reset.
- States: IDLE, ADDR, DATA. Only one burst is outstanding at a time.
- IDLE: req_ready=1. On req_valid, capture the address into ARADDR and go to ADDR.
  - WRAP_MODE=0: ARADDR = req_addr with the low log2(BURST_LEN*DATA_W/8) bits cleared.
  - WRAP_MODE=1: ARADDR = req_addr with the low log2(DATA_W/8) bits cleared.
  - ARVALID is registered and rises on the same edge.
- ADDR: ARVALID=1. ARADDR is held stable until ARREADY. On ARVALID&&ARREADY, go to DATA, deassert ARVALID and clear the beat counter. Leaving ADDR is legal only through the handshake; there is no timeout.
- DATA:
  - RREADY = rsp_ready (combinational).
  - rsp_valid = RVALID. rsp_data = RDATA. rsp_err = RRESP[1].
  - rsp_last = (beat counter == BURST_LEN-1).
  - On RVALID&&RREADY the counter increments. The beat with counter==BURST_LEN-1 returns the block to IDLE.
  - Beats with an error response are still delivered; the burst is never aborted.
- Outside DATA: rsp_valid=0 and RREADY=0. An RVALID seen outside DATA is ignored, but sets proto_err.
- proto_err is set on any accepted beat where:
  - RID != ID_VAL, or
  - RLAST != rsp_last (early or missing RLAST).
  The beat count always governs termination; RLAST never does. proto_err clears only on reset.
- Minimum latency: request accepted at cycle 0, ARVALID at cycle 1. With ARREADY=1, the first beat can be consumed at cycle 2. Back-to-back requests are accepted on the cycle after the last beat.
- ARLEN is a constant 8-bit value with the upper bits zero. The counter width is max(1, log2(BURST_LEN)). With BURST_LEN=1, every beat is last.
- An AR handshake and a req_valid in the same cycle have no interaction: req_ready=0 outside IDLE.

Test Plan:
- BURST_LEN=4, DATA_W=32, WRAP_MODE=0, req_addr=0x1000_0014 -> ARADDR=0x1000_0010, ARLEN=3, ARSIZE=2, ARBURST=01. Four beats 0xA0..0xA3 delivered in order; rsp_last only on 0xA3; back in IDLE the next cycle.
- WRAP_MODE=1, req_addr=0x2000_0008 -> ARADDR=0x2000_0008, ARBURST=10; four beats delivered with proto_err=0.
- ARREADY held low for 5 cycles -> ARVALID stays 1 and ARADDR stays stable. rsp_ready toggled 1/0 every cycle -> RREADY mirrors it; no beat is lost or duplicated.
- RRESP=2'b10 on beat 2 -> rsp_err=1 on that beat only; the burst completes normally.
- RLAST on beat 1 of 4 -> proto_err=1 and stays set; the burst still ends after beat 3. RID=5 with ID_VAL=0 -> proto_err=1.
- ARESETn pulsed low mid-DATA (after beat 1) -> all outputs drop to 0 immediately. Once reset is released, a new request issues a fresh AR.
